scan_ctrl4: RTL

- Sequential front-end for a 4-digit multiplexed display.
- Divides the system clock into a digit-scan rate and cycles a 2-bit digit index 0→1→2→3→0.
- Selects the matching 4-bit nibble from a frame-coherent shadow copy of the 16-bit display word.
- The 2-bit index feeds a 2-to-4 one-hot decoder that drives the per-digit enables, so this block sits directly upstream of that decoder.

---
 rtl/scan_ctrl4_pkg.sv | 24 ++
 rtl/scan_ctrl4_dec2to4.sv | 20 ++
 rtl/scan_ctrl4.sv | 113 +++++++++++
 3 files changed

// File: rtl/scan_ctrl4_pkg.sv
// Shared constants and helpers for the 4-digit scan controller.
package scan_ctrl4_pkg;

  localparam int DIGITS  = 4;
  localparam int DIGIT_W = 4;
  localparam int SEL_W   = 2;
  localparam int WORD_W  = DIGITS * DIGIT_W;

  // Return the nibble of a display word that belongs to digit index i_sel.
  function automatic logic [DIGIT_W-1:0] nibble_of(
    input logic [WORD_W-1:0] i_word,
    input logic [SEL_W-1:0]  i_sel
  );
    logic [DIGIT_W-1:0] w_res;
    w_res = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (i_sel == SEL_W'(k)) begin
        w_res = i_word[k*DIGIT_W +: DIGIT_W];
      end
    end
    return w_res;
  endfunction

endpackage

// File: rtl/scan_ctrl4_dec2to4.sv
// 2-to-4 one-hot decoder for the digit index; unmasked, the caller gates it.
module dec2to4
  import scan_ctrl4_pkg::*;
(
  input  logic [SEL_W-1:0]  i_sel,
  output logic [DIGITS-1:0] o_onehot
);

  // Procedural decode: exactly one output bit high for every index value.
  always_comb begin
    o_onehot = '0;
    case (i_sel)
      2'd0: o_onehot = 4'b0001;
      2'd1: o_onehot = 4'b0010;
      2'd2: o_onehot = 4'b0100;
      2'd3: o_onehot = 4'b1000;
    endcase
  end

endmodule

// File: rtl/scan_ctrl4.sv
// Scan front-end for a 4-digit multiplexed display.
//
// A prescaler holds each digit for PRESCALE clocks; the 2-bit index then
// steps 0->1->2->3->0. The displayed word is a shadow copy taken on the first
// enabled clock after reset (priming) and again on every 3->0 wrap, so a frame
// always shows one coherent word. blank and en gate only the digit enables.
//
// tick and frame_done are registered pulses: they are high during the first
// cycle of the new digit / new frame, i.e. the cycle after the advancing edge.
module scan_ctrl4
  import scan_ctrl4_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WORD_W-1:0]  din,
  input  logic [DIGITS-1:0]  blank,
  output logic [SEL_W-1:0]   sel,
  output logic [DIGIT_W-1:0] nibble,
  output logic [DIGITS-1:0]  digit_en,
  output logic               tick,
  output logic               frame_done
);

  // Prescaler width; a PRESCALE of 1 still keeps a 1-bit counter that stays 0.
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0]     r_cnt;
  logic [SEL_W-1:0]  r_sel;
  logic [WORD_W-1:0] r_shadow;
  logic              r_primed;
  logic              r_tick;
  logic              r_frame_done;

  logic [CW-1:0]     w_cnt_nxt;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic [WORD_W-1:0] w_shadow_nxt;
  logic              w_primed_nxt;
  logic              w_tick_nxt;
  logic              w_frame_done_nxt;
  logic              w_cnt_last;
  logic              w_sel_last;
  logic [DIGITS-1:0] w_onehot;

  assign w_cnt_last = (r_cnt == CW'(PRESCALE - 1));
  assign w_sel_last = (r_sel == SEL_W'(DIGITS - 1));

  // Next-state logic: prime once, then run the prescaler and digit index.
  // With en low everything holds and the pulses drop.
  always_comb begin
    w_cnt_nxt        = r_cnt;
    w_sel_nxt        = r_sel;
    w_shadow_nxt     = r_shadow;
    w_primed_nxt     = r_primed;
    w_tick_nxt       = 1'b0;
    w_frame_done_nxt = 1'b0;
    if (en) begin
      if (!r_primed) begin
        // Priming clock: capture the first word, keep cnt/sel where they are.
        w_shadow_nxt = din;
        w_primed_nxt = 1'b1;
      end else if (w_cnt_last) begin
        w_cnt_nxt  = '0;
        w_sel_nxt  = r_sel + SEL_W'(1);
        w_tick_nxt = 1'b1;
        if (w_sel_last) begin
          // New frame starts: refresh the shadow on the same edge as the wrap.
          w_shadow_nxt     = din;
          w_frame_done_nxt = 1'b1;
        end
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_sel        <= '0;
      r_shadow     <= '0;
      r_primed     <= 1'b0;
      r_tick       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_sel        <= w_sel_nxt;
      r_shadow     <= w_shadow_nxt;
      r_primed     <= w_primed_nxt;
      r_tick       <= w_tick_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  dec2to4 u_dec (
    .i_sel    (r_sel),
    .o_onehot (w_onehot)
  );

  // Output drive: raw one-hot masked by live blank and by en/primed, so the
  // result is one-hot or all zero.
  always_comb begin
    sel        = r_sel;
    nibble     = nibble_of(r_shadow, r_sel);
    digit_en   = w_onehot & ~blank & {DIGITS{en & r_primed}};
    tick       = r_tick;
    frame_done = r_frame_done;
  end

endmodule
